bmp_stream_writer: RTL and testbench
====================================

// Module: bmp_stream_writer
// PURPOSE
// - Writer end of the BMP file interface: serialises a cropped 24-bit image into a byte-wide
//   write memory as a complete BMP file, so the testbench can $fwrite it byte-for-byte.
// - Emits the 54-byte header, then bottom-up BGR pixel rows with 4-byte row padding.
// - Sits after the bounding-box/crop engine in top; pixels arrive on a valid/ready stream.
// PARAMETERS
// - ADDR_W  15  write-memory byte address width (covers files up to 32 KiB)
// - DIM_W   16  width/height field width
// PORTS
// - CLOCK_50   in   1        single clock, rising edge
// - KEY3       in   1        reset, asynchronous, active-low (driven from KEY[3])
// - start      in   1        1-cycle pulse; latches width/height; ignored unless idle or done
// - width      in   DIM_W    image width in pixels
// - height     in   DIM_W    image height in rows
// - pix_valid  in   1        pixel stream valid
// - pix_data   in   24       {R,G,B}; rows bottom-up, left to right
// - pix_ready  out  1        pixel accepted when pix_valid & pix_ready
// - mem_we     out  1        write strobe, one byte per cycle
// - mem_addr   out  ADDR_W   byte address, starts at 0, +1 per write
// - mem_wdata  out  8        byte to write
// - busy       out  1        high from the cycle after start until done
// - done       out  1        level; high after the last byte, cleared by next accepted start
// - file_size  out  32       total bytes of file; valid from CALC onward
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-file aborts at once; memory keeps
//   a partial file; next start rewrites from address 0.
// - FSM: IDLE -> CALC (1 cycle) -> HDR (54 cycles) -> PIX <-> PAD -> DONE; DONE->CALC on start.
// - CALC: rowb = width*3 via shift-add; stride = (rowb+3)&~3; pad = stride-rowb (0..3);
//   img_size = stride*height (32 bit); file_size = 54 + img_size. All unsigned, truncating.
// - HDR: byte i = 0..53, little-endian: "BM", file_size, 0(4), 54, 40, width(32),
//   height(32), planes=1(16), bpp=24(16), compression=0, img_size, 2835, 2835, 0, 0.
// - Latency: start at cycle t -> first mem_we at t+2 (addr 0 = 0x42).
// - PIX: byte phase 0..2. Phase 0: pix_ready=1; on handshake write B, hold G,R; phases 1,2
//   write G,R unconditionally (pix_ready=0). No handshake in phase 0 -> mem_we=0 and
//   mem_addr holds. Peak rate 1 pixel / 3 cycles.
// - After the last pixel of a row: PAD writes pad zero bytes (skipped if pad=0); then the
//   next row, or DONE after row height-1.
// - width=0 or height=0: header only (file_size 54), HDR -> DONE, pix_ready never asserted.
// - DONE: busy=0, done=1, mem_we=0. start during CALC/HDR/PIX/PAD ignored.
// - mem_addr never exceeds file_size-1; files >2^ADDR_W bytes unsupported (addr wraps).
// STRUCTURE
// - Package bmp_pkg: BMP_HDR_BYTES=54, BMP_DIB_SIZE=40, BMP_BPP=24, BMP_PPM=2835,
//   enum writer state {IDLE,CALC,HDR,PIX,PAD,DONE}.
// - Sub-module bmp_hdr_byte: combinational (index, width, height, img_size, file_size) -> byte.
// - Top level: FSM, byte-phase/column/row/pad counters, address counter, size registers.
// TESTING
// - 1x1, pixel 0xAABBCC -> 58 bytes: bytes 0..5 = 42 4D 3A 00 00 00; bytes 54..57 = CC BB AA 00;
//   done high at cycle t+2+58.
// - 4x2, pix_valid always 1 -> stride 12, pad 0, file 78; bytes 34..37 = 18 00 00 00; no PAD.
// - 5x2 -> stride 16, pad 1, file 86; bytes 69 and 85 = 00; pixel 6 B-byte at addr 70.
// - 5x2 with pix_valid high every other phase-0 cycle -> memory identical to previous case;
//   mem_we low on every stall cycle.
// - width=0, height=7 -> 54 bytes, file_size 54, pix_ready never high, done set.
// - KEY3 low mid-PIX -> next cycle busy=0, done=0, mem_we=0; restart 4x2 -> correct 78-byte file;
//   start pulsed while busy -> no effect on the file.

Source files
------------

// File: rtl/bmp_pkg.sv
// bmp_pkg
//   Shared constants and the writer state type for the BMP stream writer.
//   BMP_HDR_BYTES : length of the BITMAPFILEHEADER + BITMAPINFOHEADER
//   BMP_DIB_SIZE  : BITMAPINFOHEADER size field
//   BMP_BPP       : bits per pixel (24-bit BGR)
//   BMP_PPM       : pixels per metre (72 dpi)
package bmp_pkg;

    localparam int BMP_HDR_BYTES = 54;
    localparam int BMP_DIB_SIZE  = 40;
    localparam int BMP_BPP       = 24;
    localparam int BMP_PPM       = 2835;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        HDR,
        PIX,
        PAD,
        DONE
    } wr_state_e;

endpackage

// File: rtl/bmp_hdr_byte.sv
// bmp_hdr_byte
//   Combinational lookup of one byte of the 54-byte BMP header.
//   idx_i       : header byte index 0..53
//   width_i     : image width in pixels
//   height_i    : image height in rows
//   img_size_i  : pixel array size in bytes (rows padded to 4 bytes)
//   file_size_i : total file size in bytes
//   hdr_byte_o  : header byte at idx_i
module bmp_hdr_byte
    import bmp_pkg::*;
#(
    parameter int DIM_W = 16
) (
    input  logic [5:0]       idx_i,
    input  logic [DIM_W-1:0] width_i,
    input  logic [DIM_W-1:0] height_i,
    input  logic [31:0]      img_size_i,
    input  logic [31:0]      file_size_i,
    output logic [7:0]       hdr_byte_o
);

    logic [5:0]  off;
    logic [31:0] field;

    // After the "BM" signature the header is a run of 32-bit little-endian
    // words; planes and bpp share one word as {bpp, planes}.
    always_comb begin
        off   = idx_i - 6'd2;
        field = '0;
        case (off[5:2])
            4'd0:       field = file_size_i;
            4'd2:       field = 32'(BMP_HDR_BYTES);
            4'd3:       field = 32'(BMP_DIB_SIZE);
            4'd4:       field = 32'(width_i);
            4'd5:       field = 32'(height_i);
            4'd6:       field = {16'(BMP_BPP), 16'd1};
            4'd8:       field = img_size_i;
            4'd9, 4'd10: field = 32'(BMP_PPM);
            default:    field = '0;
        endcase

        hdr_byte_o = field[{off[1:0], 3'b000} +: 8];
        if (idx_i == 6'd0) begin
            hdr_byte_o = 8'h42;
        end else if (idx_i == 6'd1) begin
            hdr_byte_o = 8'h4D;
        end
    end

endmodule

// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer
//   Serialises a 24-bit image arriving on a valid/ready pixel stream into a
//   byte-wide write memory as a complete BMP file (header, bottom-up BGR rows,
//   rows padded to a multiple of 4 bytes).
//   CLOCK_50  : clock, rising edge
//   KEY3      : asynchronous active-low reset
//   start     : 1-cycle pulse, latches width/height (accepted in IDLE or DONE)
//   width     : image width in pixels
//   height    : image height in rows
//   pix_valid : pixel stream valid
//   pix_data  : {R,G,B}
//   pix_ready : pixel accepted on pix_valid & pix_ready
//   mem_we    : byte write strobe
//   mem_addr  : byte address, 0 upward
//   mem_wdata : byte to write
//   busy      : file in progress
//   done      : file complete, cleared by the next accepted start
//   file_size : total file size in bytes
module bmp_stream_writer
    import bmp_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DIM_W  = 16
) (
    input  logic              CLOCK_50,
    input  logic              KEY3,
    input  logic              start,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       file_size
);

    wr_state_e         state_q;
    logic [DIM_W-1:0]  width_q, height_q;
    logic [DIM_W-1:0]  col_q, row_q;
    logic [1:0]        pad_q, pad_cnt_q, phase_q;
    logic [31:0]       img_size_q, file_size_q;
    logic [5:0]        hdr_idx_q;
    logic [15:0]       hold_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              pix_ready_q, mem_we_q, busy_q, done_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;

    logic [31:0] rowb_c, stride_c, img_size_c;
    logic [1:0]  pad_c;
    logic [7:0]  hdr_byte;
    logic        we_c;
    logic [7:0]  wdata_c;
    logic        start_ok, hdr_last, col_last, row_last, empty_img;

    // Sizes are derived from the raw inputs and captured together with the
    // dimensions, so file_size is already valid while the FSM sits in CALC.
    always_comb begin
        rowb_c     = (32'(width) << 1) + 32'(width);
        stride_c   = (rowb_c + 32'd3) & ~32'd3;
        pad_c      = 2'(stride_c - rowb_c);
        img_size_c = stride_c * 32'(height);
    end

    bmp_hdr_byte #(.DIM_W(DIM_W)) u_hdr (
        .idx_i       (hdr_idx_q),
        .width_i     (width_q),
        .height_i    (height_q),
        .img_size_i  (img_size_q),
        .file_size_i (file_size_q),
        .hdr_byte_o  (hdr_byte)
    );

    assign start_ok  = start && ((state_q == IDLE) || ((state_q == DONE) && done_q));
    assign hdr_last  = (hdr_idx_q == 6'(BMP_HDR_BYTES - 1));
    assign col_last  = (col_q == width_q - DIM_W'(1));
    assign row_last  = (row_q == height_q - DIM_W'(1));
    assign empty_img = (width_q == '0) || (height_q == '0);

    // Byte chosen for the write issued at the coming edge.
    always_comb begin
        we_c    = 1'b0;
        wdata_c = 8'h00;
        case (state_q)
            CALC, HDR: begin
                we_c    = 1'b1;
                wdata_c = hdr_byte;
            end
            PIX: begin
                case (phase_q)
                    2'd0: begin
                        we_c    = pix_valid && pix_ready_q;
                        wdata_c = pix_data[7:0];
                    end
                    2'd1: begin
                        we_c    = 1'b1;
                        wdata_c = hold_q[7:0];
                    end
                    2'd2: begin
                        we_c    = 1'b1;
                        wdata_c = hold_q[15:8];
                    end
                    default: ;
                endcase
            end
            PAD: begin
                we_c    = 1'b1;
                wdata_c = 8'h00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY3) begin
        if (!KEY3) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pad_q       <= '0;
            pad_cnt_q   <= '0;
            phase_q     <= '0;
            img_size_q  <= '0;
            file_size_q <= '0;
            hdr_idx_q   <= '0;
            hold_q      <= '0;
            wr_addr_q   <= '0;
            pix_ready_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_we_q <= we_c;
            if (we_c) begin
                mem_addr_q  <= wr_addr_q;
                mem_wdata_q <= wdata_c;
                wr_addr_q   <= wr_addr_q + ADDR_W'(1);
            end

            if (start_ok) begin
                state_q     <= CALC;
                width_q     <= width;
                height_q    <= height;
                pad_q       <= pad_c;
                img_size_q  <= img_size_c;
                file_size_q <= 32'(BMP_HDR_BYTES) + img_size_c;
                hdr_idx_q   <= '0;
                wr_addr_q   <= '0;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
            end else begin
                case (state_q)
                    CALC: begin
                        hdr_idx_q <= 6'd1;
                        state_q   <= HDR;
                    end
                    HDR: begin
                        hdr_idx_q <= hdr_idx_q + 6'd1;
                        if (hdr_last) begin
                            col_q <= '0;
                            row_q <= '0;
                            if (empty_img) begin
                                state_q <= DONE;
                            end else begin
                                state_q     <= PIX;
                                phase_q     <= 2'd0;
                                pix_ready_q <= 1'b1;
                            end
                        end
                    end
                    PIX: begin
                        case (phase_q)
                            2'd0: begin
                                if (pix_valid && pix_ready_q) begin
                                    hold_q      <= pix_data[23:8];
                                    phase_q     <= 2'd1;
                                    pix_ready_q <= 1'b0;
                                end
                            end
                            2'd1: phase_q <= 2'd2;
                            2'd2: begin
                                phase_q <= 2'd0;
                                if (!col_last) begin
                                    col_q       <= col_q + DIM_W'(1);
                                    pix_ready_q <= 1'b1;
                                end else begin
                                    col_q <= '0;
                                    if (pad_q != 2'd0) begin
                                        state_q   <= PAD;
                                        pad_cnt_q <= pad_q;
                                    end else if (row_last) begin
                                        state_q <= DONE;
                                    end else begin
                                        row_q       <= row_q + DIM_W'(1);
                                        pix_ready_q <= 1'b1;
                                    end
                                end
                            end
                            default: phase_q <= 2'd0;
                        endcase
                    end
                    PAD: begin
                        pad_cnt_q <= pad_cnt_q - 2'd1;
                        if (pad_cnt_q == 2'd1) begin
                            if (row_last) begin
                                state_q <= DONE;
                            end else begin
                                row_q       <= row_q + DIM_W'(1);
                                state_q     <= PIX;
                                phase_q     <= 2'd0;
                                pix_ready_q <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        // First DONE cycle still carries the last byte; flag completion after it.
                        if (!done_q) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pix_ready = pix_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign file_size = file_size_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
module tb_bmp_stream_writer;

    logic        clk = 1'b0;
    logic        KEY3;
    logic        start;
    logic [15:0] width, height;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready, mem_we, busy, done;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [31:0] file_size;

    bmp_stream_writer #(.ADDR_W(15), .DIM_W(16)) dut (
        .CLOCK_50  (clk),
        .KEY3      (KEY3),
        .start     (start),
        .width     (width),
        .height    (height),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .file_size (file_size)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [23:0] pixq[$];
    logic [7:0]  mem[256];
    logic [7:0]  saved[256];
    int          exp_addr;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          first_we, done_cyc, nwr, stalls;
    bit          ready_seen, prev_stall;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push8(input logic [7:0] b);
        exp_q.push_back('{addr: exp_addr, data: b});
        exp_addr++;
    endtask

    task automatic push32(input logic [31:0] w);
        for (int i = 0; i < 4; i++) push8(w[8*i +: 8]);
    endtask

    task automatic push16(input logic [15:0] w);
        push8(w[7:0]);
        push8(w[15:8]);
    endtask

    // Reference BMP file built straight from the format definition.
    task automatic build_exp(input int w, input int h, output int fsz);
        int rowb, stride, img, pad;
        rowb   = w * 3;
        stride = (rowb + 3) & ~3;
        pad    = stride - rowb;
        img    = stride * h;
        fsz    = 54 + img;
        exp_q.delete();
        exp_addr = 0;
        push8(8'h42); push8(8'h4D);
        push32(fsz); push32(0); push32(54); push32(40);
        push32(w); push32(h); push16(1); push16(24);
        push32(0); push32(img); push32(2835); push32(2835); push32(0); push32(0);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                push8(pixq[r*w+c][7:0]);
                push8(pixq[r*w+c][15:8]);
                push8(pixq[r*w+c][23:16]);
            end
            for (int p = 0; p < pad; p++) push8(8'h00);
        end
    endtask

    always @(negedge clk) begin
        if (KEY3) begin
            if (mem_we) begin
                exp_t e;
                if (first_we < 0) first_we = cyc;
                mem[mem_addr[7:0]] = mem_wdata;
                nwr++;
                if (exp_q.size() == 0) begin
                    chk("extra_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (prev_stall) chk("stall_we", 32'(mem_we), 32'd0);
            prev_stall = pix_ready && !pix_valid;
            if (prev_stall) stalls++;
            if (pix_ready) ready_seen = 1'b1;
            if (done && done_cyc < 0) done_cyc = cyc;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic run_image(input int w, input int h, input int mode,
                             input int abort_px, input bit poke);
        int  fsz, t, idx, n, npix;
        bit  hs, tog;
        npix = w * h;
        build_exp(w, h, fsz);
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        first_we = -1; nwr = 0; ready_seen = 1'b0; stalls = 0;
        @(posedge clk); #1;
        width = 16'(w); height = 16'(h); start = 1'b1; t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        done_cyc = -1;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        idx = 0; n = 0; tog = 1'b0;
        while (idx < npix && n < 2000 && !(abort_px > 0 && idx >= abort_px)) begin
            if (mode == 1) begin
                if (pix_ready) begin
                    pix_valid = tog;
                    tog = !tog;
                end else begin
                    pix_valid = 1'b0;
                end
            end else begin
                pix_valid = 1'b1;
            end
            pix_data = pixq[idx];
            start = poke && (n == 10);
            if (start) width = 16'd9;
            @(negedge clk);
            hs = pix_ready && pix_valid;
            @(posedge clk); #1;
            if (hs) idx++;
            n++;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        if (abort_px > 0) begin
            KEY3 = 1'b0;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_we", 32'(mem_we), 32'd0);
            chk("abort_ready", 32'(pix_ready), 32'd0);
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1;
            KEY3 = 1'b1;
            return;
        end
        chk("feed_complete", 32'(idx), 32'(npix));
        n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk); #1;
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("first_we_cyc", 32'(first_we), 32'(t + 2));
        if (mode == 0) chk("done_cyc", 32'(done_cyc), 32'(t + 2 + fsz));
        chk("file_size", file_size, 32'(fsz));
        chk("n_writes", 32'(nwr), 32'(fsz));
        chk("exp_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic make_pix(input int n);
        pixq.delete();
        for (int i = 0; i < n; i++)
            pixq.push_back({8'(i * 17 + 1), 8'(i * 29 + 2), 8'(i * 41 + 3)});
    endtask

    initial begin
        int diffs;
        KEY3 = 1'b0; start = 1'b0; width = '0; height = '0;
        pix_valid = 1'b0; pix_data = '0;
        first_we = -1; done_cyc = -1; nwr = 0; stalls = 0;
        ready_seen = 1'b0; prev_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(pix_ready), 32'd0);
        chk("rst_fsize", file_size, 32'd0);
        KEY3 = 1'b1;
        repeat (2) @(posedge clk);

        // 1x1
        pixq.delete();
        pixq.push_back(24'hAABBCC);
        run_image(1, 1, 0, 0, 1'b0);
        chk("1x1_b0_3", {mem[3], mem[2], mem[1], mem[0]}, 32'h003A4D42);
        chk("1x1_b4_5", {16'h0, mem[5], mem[4]}, 32'h0000_0000);
        chk("1x1_b54_57", {mem[57], mem[56], mem[55], mem[54]}, 32'h00AABBCC);

        // 4x2, no padding
        make_pix(8);
        run_image(4, 2, 0, 0, 1'b0);
        chk("4x2_img_size", {mem[37], mem[36], mem[35], mem[34]}, 32'h0000_0018);
        chk("4x2_fsize", file_size, 32'd78);

        // 5x2, one pad byte per row
        make_pix(10);
        run_image(5, 2, 0, 0, 1'b0);
        chk("5x2_fsize", file_size, 32'd86);
        chk("5x2_pad69", 32'(mem[69]), 32'd0);
        chk("5x2_pad85", 32'(mem[85]), 32'd0);
        chk("5x2_px6_b", 32'(mem[70]), 32'(pixq[5][7:0]));
        for (int i = 0; i < 256; i++) saved[i] = mem[i];

        // 5x2 with stalls on every other ready cycle
        run_image(5, 2, 1, 0, 1'b0);
        diffs = 0;
        for (int i = 0; i < 86; i++) if (mem[i] !== saved[i]) diffs++;
        chk("5x2_stall_same", 32'(diffs), 32'd0);
        chk("5x2_stalls_seen", 32'(stalls > 0), 32'd1);

        // empty image
        pixq.delete();
        run_image(0, 7, 0, 0, 1'b0);
        chk("w0_fsize", file_size, 32'd54);
        chk("w0_no_ready", 32'(ready_seen), 32'd0);

        // reset mid-PIX, then restart with a start poke while busy
        make_pix(8);
        run_image(4, 2, 0, 3, 1'b0);
        run_image(4, 2, 0, 0, 1'b1);
        chk("restart_fsize", file_size, 32'd78);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
